// File: rtl/reg_write_arbiter_pkg.sv
// reg_write_arbiter_pkg: shared widths and the default number of writeback sources for the register-file write arbiter
package reg_write_arbiter_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int NUM_WB_REQ = 4;
endpackage

// File: rtl/reg_write_arbiter_rr_picker.sv
// reg_write_arbiter_rr_picker: combinational rotate-priority encoder, first set req bit scanning from ptr upward modulo NUM_REQ
// ports: req (request vector), ptr (scan start), grant_onehot/grant_idx (winner), any (some request set)
module reg_write_arbiter_rr_picker #(
  parameter int NUM_REQ = 4,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [PW-1:0]      grant_idx,
  output logic               any
);
  logic [PW-1:0] j;
  // scan backwards so the candidate closest to ptr overwrites the others
  always_comb begin
    grant_onehot = '0;
    grant_idx = '0;
    any = 1'b0;
    j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = PW'((int'(ptr) + k) % NUM_REQ);
      if (req[j]) begin
        grant_onehot = '0;
        grant_onehot[j] = 1'b1;
        grant_idx = j;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin share of the register-file write port between NUM_REQ writeback sources, with a registered output stage and two bypass lookups
// ports: clk_in/rst_in (async active-high), rdy_in (pause), flush_in (block new accepts),
//        req_valid/req_id/req_val/req_ready (per-requester handshake, packed),
//        set_reg_id/set_val (register file write, id 0 = none),
//        byp_idK/byp_hitK/byp_valK (pending-write lookups), busy (output stage holds a write)
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_WB_REQ,
  parameter int XLEN = DEF_XLEN,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          flush_in,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_id,
  input  logic [NUM_REQ*XLEN-1:0]       req_val,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [REG_ADDR_W-1:0]         set_reg_id,
  output logic [XLEN-1:0]               set_val,
  input  logic [REG_ADDR_W-1:0]         byp_id1,
  output logic                          byp_hit1,
  output logic [XLEN-1:0]               byp_val1,
  input  logic [REG_ADDR_W-1:0]         byp_id2,
  output logic                          byp_hit2,
  output logic [XLEN-1:0]               byp_val2,
  output logic                          busy
);
  localparam int PW = $clog2(NUM_REQ);
  logic                  out_valid;
  logic [REG_ADDR_W-1:0] out_id;
  logic [XLEN-1:0]       out_val;
  logic [PW-1:0]         rr_ptr;
  logic [NUM_REQ-1:0]    open_req;
  logic [PW-1:0]         win;
  logic                  accept;
  logic [REG_ADDR_W-1:0] ids [NUM_REQ];
  logic [XLEN-1:0]       vals [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign ids[i] = req_id[i*REG_ADDR_W +: REG_ADDR_W];
    assign vals[i] = req_val[i*XLEN +: XLEN];
  end
  // masking the requests here keeps req_ready low while paused or flushing
  assign open_req = (rdy_in && !flush_in) ? req_valid : '0;
  reg_write_arbiter_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req(open_req),
    .ptr(rr_ptr),
    .grant_onehot(req_ready),
    .grant_idx(win),
    .any(accept)
  );
  // x0 writes are consumed but latched invalid so they never reach the register file
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      out_valid <= 1'b0;
      out_id <= '0;
      out_val <= '0;
      rr_ptr <= '0;
    end else if (rdy_in) begin
      out_valid <= accept && (ids[win] != '0);
      if (accept) begin
        out_id <= ids[win];
        out_val <= vals[win];
        rr_ptr <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end
    end
  end
  assign set_reg_id = out_valid ? out_id : '0;
  assign set_val = out_val;
  assign busy = out_valid;
  assign byp_hit1 = out_valid && (out_id == byp_id1) && (byp_id1 != '0);
  assign byp_hit2 = out_valid && (out_id == byp_id2) && (byp_id2 != '0);
  assign byp_val1 = byp_hit1 ? out_val : '0;
  assign byp_val2 = byp_hit2 ? out_val : '0;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed stimulus with a scoreboard of expected register-file writes, popped as each write commits
module tb_reg_write_arbiter;
  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         rdy_in;
  logic         flush_in;
  logic [3:0]   req_valid;
  logic [19:0]  req_id;
  logic [127:0] req_val;
  logic [3:0]   req_ready;
  logic [4:0]   set_reg_id;
  logic [31:0]  set_val;
  logic [4:0]   byp_id1;
  logic         byp_hit1;
  logic [31:0]  byp_val1;
  logic [4:0]   byp_id2;
  logic         byp_hit2;
  logic [31:0]  byp_val2;
  logic         busy;
  typedef struct {
    logic [4:0]  id;
    logic [31:0] val;
  } wr_t;
  wr_t sb[$];
  int n_checks = 0;
  int n_errors = 0;
  reg_write_arbiter dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .flush_in(flush_in),
    .req_valid(req_valid),
    .req_id(req_id),
    .req_val(req_val),
    .req_ready(req_ready),
    .set_reg_id(set_reg_id),
    .set_val(set_val),
    .byp_id1(byp_id1),
    .byp_hit1(byp_hit1),
    .byp_val1(byp_val1),
    .byp_id2(byp_id2),
    .byp_hit2(byp_hit2),
    .byp_val2(byp_val2),
    .busy(busy)
  );
  always #5 clk_in = ~clk_in;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask
  task automatic set_req(input int i, input logic [4:0] id, input logic [31:0] v);
    req_id[i*5 +: 5] = id;
    req_val[i*32 +: 32] = v;
  endtask
  task automatic push(input logic [4:0] id, input logic [31:0] v);
    wr_t e;
    e.id = id;
    e.val = v;
    sb.push_back(e);
  endtask
  // a write lands on the next edge whenever rdy_in is high and set_reg_id is nonzero
  always @(negedge clk_in) begin
    if (!rst_in && rdy_in && set_reg_id != 5'd0) begin
      if (sb.size() == 0) check("commit_unexpected", 64'(set_reg_id), 64'(0));
      else begin
        wr_t e;
        e = sb.pop_front();
        check("commit_id", 64'(set_reg_id), 64'(e.id));
        check("commit_val", 64'(set_val), 64'(e.val));
      end
    end
  end
  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    flush_in = 1'b0;
    req_valid = '0;
    req_id = '0;
    req_val = '0;
    byp_id1 = 5'd5;
    byp_id2 = 5'd6;
    repeat (2) step();
    check("rst_set_reg_id", 64'(set_reg_id), 64'(0));
    check("rst_set_val", 64'(set_val), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_byp_hit1", 64'(byp_hit1), 64'(0));
    rst_in = 1'b0;
    // basic write
    set_req(0, 5'd5, 32'hDEADBEEF);
    req_valid = 4'b0001;
    #1;
    check("basic_ready", 64'(req_ready), 64'(4'b0001));
    push(5'd5, 32'hDEADBEEF);
    step();
    req_valid = '0;
    #1;
    check("basic_set_reg_id", 64'(set_reg_id), 64'(5));
    check("basic_set_val", 64'(set_val), 64'(32'hDEADBEEF));
    check("basic_busy", 64'(busy), 64'(1));
    check("basic_byp_hit1", 64'(byp_hit1), 64'(1));
    check("basic_byp_val1", 64'(byp_val1), 64'(32'hDEADBEEF));
    check("basic_byp_hit2", 64'(byp_hit2), 64'(0));
    check("basic_byp_val2", 64'(byp_val2), 64'(0));
    step();
    check("basic_clear", 64'(set_reg_id), 64'(0));
    check("basic_clear_hit1", 64'(byp_hit1), 64'(0));
    // fairness from a fresh pointer
    rst_in = 1'b1;
    #1;
    rst_in = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 5'(i + 1), 32'h100 + 32'(i));
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("fair_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      if (k > 0) check("fair_set_reg_id", 64'(set_reg_id), 64'(((k - 1) % 4) + 1));
      push(5'((k % 4) + 1), 32'h100 + 32'(k % 4));
      step();
    end
    req_valid = '0;
    #1;
    check("fair_last", 64'(set_reg_id), 64'(1));
    step();
    check("fair_idle", 64'(set_reg_id), 64'(0));
    // x0 request from requester 1 (pointer is at 1)
    set_req(1, 5'd0, 32'h55);
    req_valid = 4'b0010;
    byp_id1 = 5'd0;
    #1;
    check("x0_ready", 64'(req_ready), 64'(4'b0010));
    step();
    req_valid = '0;
    #1;
    check("x0_set_reg_id", 64'(set_reg_id), 64'(0));
    check("x0_busy", 64'(busy), 64'(0));
    check("x0_byp_hit1", 64'(byp_hit1), 64'(0));
    set_req(1, 5'd2, 32'h101);
    req_valid = 4'b1111;
    #1;
    check("x0_ptr_next", 64'(req_ready), 64'(4'b0100));
    push(5'd3, 32'h102);
    step();
    req_valid = '0;
    step();
    // pause with id 7 pending (pointer at 3)
    set_req(3, 5'd7, 32'h11);
    req_valid = 4'b1000;
    #1;
    check("pause_grant", 64'(req_ready), 64'(4'b1000));
    push(5'd7, 32'h11);
    step();
    req_valid = 4'b0001;
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("pause_set_reg_id", 64'(set_reg_id), 64'(7));
      check("pause_ready", 64'(req_ready), 64'(0));
      check("pause_busy", 64'(busy), 64'(1));
      step();
    end
    rdy_in = 1'b1;
    req_valid = '0;
    #1;
    check("pause_resume", 64'(set_reg_id), 64'(7));
    step();
    check("pause_done", 64'(set_reg_id), 64'(0));
    // flush with id 9 latched (pointer at 0)
    set_req(0, 5'd9, 32'h22);
    req_valid = 4'b0001;
    #1;
    check("flush_grant", 64'(req_ready), 64'(4'b0001));
    push(5'd9, 32'h22);
    step();
    flush_in = 1'b1;
    req_valid = 4'b1111;
    byp_id1 = 5'd5;
    byp_id2 = 5'd9;
    #1;
    check("flush_ready", 64'(req_ready), 64'(0));
    check("flush_set_reg_id", 64'(set_reg_id), 64'(9));
    check("flush_set_val", 64'(set_val), 64'(32'h22));
    check("flush_byp_hit2", 64'(byp_hit2), 64'(1));
    check("flush_byp_val2", 64'(byp_val2), 64'(32'h22));
    check("flush_byp_hit1", 64'(byp_hit1), 64'(0));
    check("flush_byp_val1", 64'(byp_val1), 64'(0));
    step();
    flush_in = 1'b0;
    req_valid = '0;
    #1;
    check("flush_clear", 64'(set_reg_id), 64'(0));
    req_valid = 4'b1111;
    #1;
    check("flush_ptr_held", 64'(req_ready), 64'(4'b0010));
    req_valid = '0;
    // async reset with id 12 pending (pointer at 1)
    set_req(1, 5'd12, 32'hC0C0);
    req_valid = 4'b0010;
    #1;
    check("areset_grant", 64'(req_ready), 64'(4'b0010));
    push(5'd12, 32'hC0C0);
    step();
    req_valid = '0;
    #1;
    check("areset_pending", 64'(set_reg_id), 64'(12));
    rst_in = 1'b1;
    #1;
    check("areset_set_reg_id", 64'(set_reg_id), 64'(0));
    check("areset_busy", 64'(busy), 64'(0));
    check("areset_set_val", 64'(set_val), 64'(0));
    sb.delete();
    rst_in = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("areset_first_grant", 64'(req_ready), 64'(4'b0001));
    req_valid = '0;
    repeat (2) step();
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
